vram_dma_arbiter_m: RTL and testbench
=====================================

# vram_dma_arbiter_m

Sequences block copies from a CPU-side source memory into foreground VRAM, by default a full Object Memory refresh of 256 bytes to 0x800–0x8FF. It shares the single VRAM write port between direct CPU writes and the DMA engine, with the CPU always winning. DMA writes are issued only while `writable` is high. The block sits between the bus interface and the foreground/background VRAM write inputs (`data_in`, `address`, `write_enable`).

## Interface
- `DMA_LENGTH`, 256: bytes per transfer; legal range 1–256.
- `DST_BASE`, 12'h800: first VRAM destination address.
- `SRC_ADDR_WIDTH`, 16: source address width.
- `clk`  in  1  pixel clock (12.5875 MHz).
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `writable`  in  1  VRAM write window from video timing.
- `cpu_write_enable`  in  1  direct CPU VRAM write strobe.
- `cpu_address`  in  `VRAM_ADDR_WIDTH`  direct CPU write address.
- `cpu_data`  in  8  direct CPU write data.
- `start`  in  1  one-cycle request to begin a transfer.
- `abort`  in  1  cancel the active transfer.
- `src_base`  in  `SRC_ADDR_WIDTH`  source start address, latched on accepted `start`.
- `src_req`  out  1  source read request.
- `src_addr`  out  `SRC_ADDR_WIDTH`  source read address.
- `src_ack`  in  1  source read complete; `src_data` valid this cycle.
- `src_data`  in  8  source read data.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse on completion.
- `vram_address`  out  `VRAM_ADDR_WIDTH`  to VRAM `address`.
- `vram_data`  out  8  to VRAM `data_in`.
- `vram_write_enable`  out  1  to VRAM `write_enable`.

## Operation
- FSM states: IDLE, WAIT_WIN, FETCH, WRITE, DONE. Register `count` is 9 bits. Register `hold` is 8 bits.
- IDLE:
  - `start` → latch `src_base`, clear `count`, go to WAIT_WIN.
- WAIT_WIN:
  - `writable` → FETCH.
- FETCH:
  - `src_req`=1 and `src_addr`=`src_base`+`count` (mod 2^SRC_ADDR_WIDTH).
  - Both outputs hold steady until `src_ack`.
  - On `src_ack`, `hold`←`src_data` and go to WRITE.
  - Reads are not gated by `writable`.
- WRITE:
  - DMA write is granted iff `writable` && !`cpu_write_enable`.
  - On grant: VRAM address is `DST_BASE`+`count` (truncated to `VRAM_ADDR_WIDTH`) and data is `hold`.
  - On grant with `count`==`DMA_LENGTH`−1 → DONE; otherwise `count`++ and → FETCH.
  - Without grant, stay in WRITE with `hold` kept.
- DONE:
  - `done`=1 → IDLE.
- `busy` = (state != IDLE).
- `start` while busy is ignored.
- `abort` in any non-IDLE state:
  - → IDLE on the next edge, with no `done` and no DMA write in that cycle.
  - Abort has priority over grant; in FETCH a pending request is dropped.
- VRAM port mux is combinational:
  - `cpu_write_enable`=1 → pass `cpu_address`/`cpu_data`, `vram_write_enable`=1.
  - DMA grant → DMA address/data, `vram_write_enable`=1.
  - Neither → `vram_write_enable`=0, with address/data from the DMA path.
- CPU writes pass regardless of `writable`; the VRAM gates them itself.
- `src_ack` outside FETCH is ignored.

## Timing
- Reset (`rst`=0) forces IDLE immediately, asynchronously:
  - `busy`=0, `done`=0, `src_req`=0, `src_addr`=0, `count`=0, `hold`=0.
  - `vram_write_enable` = `cpu_write_enable`.
- Zero-latency mux: a CPU or DMA write appears on `vram_*` in the same cycle it is decided.
- With `writable`=1, `src_ack` in the first FETCH cycle and no CPU traffic, for `start` sampled in cycle 0:
  - WAIT_WIN is cycle 1.
  - Byte k is FETCHed in cycle 2+2k and written in cycle 3+2k.
  - `done` is high in cycle 2·`DMA_LENGTH`+2 (cycle 514 for the default).
  - IDLE follows in the next cycle.
- Each CPU collision adds exactly 1 cycle.
- Each `src_ack` wait cycle adds 1 cycle.
- A `writable`-low span in WRITE adds its full length.
- `DMA_LENGTH`=1: a single FETCH/WRITE, then DONE.

## Test plan
- Default transfer; `writable`=1; source byte at addr a = a[7:0]; `src_base`=0x1200; immediate ack:
  - 256 writes to 0x800–0x8FF with data 0x00–0xFF.
  - `done` pulses in cycle 514.
  - `busy` is high in cycles 1–514.
- `cpu_write_enable` with 0x123/0xAA in the WRITE cycle of byte 5:
  - VRAM sees 0x123/0xAA in that cycle.
  - Byte 5 (0x805) is written the next cycle.
  - Total length is 515 cycles.
- `writable` low from the WRITE of byte 100 for 40 cycles:
  - No DMA `vram_write_enable`.
  - 0x864 is written on the first cycle `writable` returns.
  - No byte is skipped or duplicated.
- Source ack delayed 3 cycles per byte:
  - `src_req`/`src_addr` stable through each wait.
  - `done` in cycle 2+5·256.
- Second `start` at byte 20 is ignored. Then `abort` at byte 10 of a new transfer:
  - Only 0x800–0x809 are written.
  - No `done`; IDLE next cycle.
- `rst` asserted mid-FETCH:
  - Outputs take reset values without a clock edge.
  - A new `start` after release runs a full transfer from `src_base`.

Source files
------------

// File: rtl/vram_dma_arbiter_m_if.sv
// Bus bundle between the CPU/video side and the VRAM DMA arbiter.
// The master side drives requests and the source memory; the slave side is the arbiter.
interface vram_dma_arbiter_m_if #(
  parameter int unsigned SRC_ADDR_WIDTH  = 16,
  parameter int unsigned VRAM_ADDR_WIDTH = 12
);
  logic                       writable;
  logic                       cpu_write_enable;
  logic [VRAM_ADDR_WIDTH-1:0] cpu_address;
  logic [7:0]                 cpu_data;
  logic                       start;
  logic                       abort;
  logic [SRC_ADDR_WIDTH-1:0]  src_base;
  logic                       src_req;
  logic [SRC_ADDR_WIDTH-1:0]  src_addr;
  logic                       src_ack;
  logic [7:0]                 src_data;
  logic                       busy;
  logic                       done;
  logic [VRAM_ADDR_WIDTH-1:0] vram_address;
  logic [7:0]                 vram_data;
  logic                       vram_write_enable;

  modport master (
    output writable, cpu_write_enable, cpu_address, cpu_data,
    output start, abort, src_base, src_ack, src_data,
    input  src_req, src_addr, busy, done,
    input  vram_address, vram_data, vram_write_enable
  );

  modport slave (
    input  writable, cpu_write_enable, cpu_address, cpu_data,
    input  start, abort, src_base, src_ack, src_data,
    output src_req, src_addr, busy, done,
    output vram_address, vram_data, vram_write_enable
  );
endinterface

// File: rtl/vram_dma_arbiter_m.sv
// Copies a block from CPU-side source memory into foreground VRAM, sharing the
// single VRAM write port with direct CPU writes (CPU always wins).
module vram_dma_arbiter_m #(
  parameter int unsigned                DMA_LENGTH      = 256,
  parameter int unsigned                SRC_ADDR_WIDTH  = 16,
  parameter int unsigned                VRAM_ADDR_WIDTH = 12,
  parameter logic [VRAM_ADDR_WIDTH-1:0] DST_BASE        = VRAM_ADDR_WIDTH'(12'h800)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vram_dma_arbiter_m_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WIN,
    S_FETCH,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [8:0] LAST_IDX = 9'(DMA_LENGTH - 1);

  state_e                     state_q, state_d;
  logic [SRC_ADDR_WIDTH-1:0]  src_base_q, src_base_d;
  logic [8:0]                 count_q, count_d;
  logic [7:0]                 hold_q, hold_d;
  logic                       aborting;
  logic                       dma_grant;
  logic                       src_req;
  logic                       done_pulse;
  logic [VRAM_ADDR_WIDTH-1:0] dma_address;

  assign aborting    = bus.abort && (state_q != S_IDLE);
  assign dma_address = DST_BASE + VRAM_ADDR_WIDTH'(count_q);

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_pulse;
  assign bus.src_req  = src_req;
  assign bus.src_addr = src_base_q + SRC_ADDR_WIDTH'(count_q);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    src_base_d = src_base_q;
    count_d    = count_q;
    hold_d     = hold_q;
    src_req    = 1'b0;
    dma_grant  = 1'b0;
    done_pulse = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          src_base_d = bus.src_base;
          count_d    = '0;
          state_d    = S_WAIT_WIN;
        end
      end
      S_WAIT_WIN: begin
        if (bus.writable) state_d = S_FETCH;
      end
      S_FETCH: begin
        src_req = 1'b1;
        if (bus.src_ack) begin
          hold_d  = bus.src_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.writable && !bus.cpu_write_enable) begin
          dma_grant = 1'b1;
          if (count_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            count_d = count_q + 9'd1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        done_pulse = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort outranks everything: no write, no done, no fetch side effect.
    if (aborting) begin
      state_d    = S_IDLE;
      src_base_d = src_base_q;
      count_d    = count_q;
      hold_d     = hold_q;
      src_req    = 1'b0;
      dma_grant  = 1'b0;
      done_pulse = 1'b0;
    end
  end

  // The CPU path needs no arbitration: a DMA grant already excludes it.
  always_comb begin
    bus.vram_address      = dma_address;
    bus.vram_data         = hold_q;
    bus.vram_write_enable = dma_grant;
    if (bus.cpu_write_enable) begin
      bus.vram_address      = bus.cpu_address;
      bus.vram_data         = bus.cpu_data;
      bus.vram_write_enable = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      src_base_q <= '0;
      count_q    <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      src_base_q <= src_base_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: tb/tb_vram_dma_arbiter_m.sv
// Self-checking bench for vram_dma_arbiter_m: directed timing scenarios plus
// randomized traffic, all compared against a transfer-level reference model.
module tb_vram_dma_arbiter_m;

  localparam int          L   = 256;
  localparam logic [11:0] DST = 12'h800;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vram_dma_arbiter_m_if #(.SRC_ADDR_WIDTH(16), .VRAM_ADDR_WIDTH(12)) bus ();

  vram_dma_arbiter_m #(
    .DMA_LENGTH     (L),
    .SRC_ADDR_WIDTH (16),
    .VRAM_ADDR_WIDTH(12),
    .DST_BASE       (DST)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scenario configuration (relative cycle numbers; -1 disables an event).
  logic [15:0] cfg_base;
  logic [7:0]  cfg_xor;
  int          cfg_ack_delay;
  bit          cfg_rand;
  int          cfg_cpu_at, cfg_wl_from, cfg_wl_len, cfg_start2_at, cfg_abort_at, cfg_rst_at;

  // Observed results of one run.
  int done_rel, done_cnt, widx, fetch_idx;
  int wcyc[L];

  // Source memory contents: low address byte, optionally scrambled.
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ cfg_xor;
  endfunction

  task automatic set_defaults(input logic [15:0] base);
    cfg_base      = base;
    cfg_xor       = 8'h00;
    cfg_ack_delay = 0;
    cfg_rand      = 1'b0;
    cfg_cpu_at    = -1;
    cfg_wl_from   = -1;
    cfg_wl_len    = 0;
    cfg_start2_at = -1;
    cfg_abort_at  = -1;
    cfg_rst_at    = -1;
  endtask

  task automatic idle_inputs();
    bus.writable         = 1'b1;
    bus.cpu_write_enable = 1'b0;
    bus.cpu_address      = '0;
    bus.cpu_data         = '0;
    bus.start            = 1'b0;
    bus.abort            = 1'b0;
    bus.src_base         = '0;
    bus.src_ack          = 1'b0;
    bus.src_data         = '0;
  endtask

  // Runs one transfer: start in relative cycle 0, inputs driven 1 time unit after
  // each rising edge, outputs sampled just before the falling edge.
  task automatic run_xfer();
    int          req_wait = 0;
    int          delay;
    logic [15:0] req_addr = '0;
    bit          finished = 1'b0;
    bit          exp_busy;
    done_rel  = -1;
    done_cnt  = 0;
    widx      = 0;
    fetch_idx = 0;
    for (int k = 0; k < L; k++) wcyc[k] = -1;
    delay = cfg_rand ? int'($urandom_range(0, 2)) : cfg_ack_delay;
    @(posedge clk); #1;
    for (int rel = 0; rel < 4000 && !finished; rel++) begin
      // Source memory responder.
      if (bus.src_req) begin
        if (req_wait == 0) begin
          req_addr = bus.src_addr;
        end else begin
          n_checks++;
          if (bus.src_addr !== req_addr) begin
            n_fail++;
            $display("FAIL src_addr_stable rel=%0d: got %h expected %h", rel, bus.src_addr, req_addr);
          end
        end
        if (req_wait == delay) begin
          n_checks++;
          if (bus.src_addr !== cfg_base + 16'(fetch_idx)) begin
            n_fail++;
            $display("FAIL fetch_addr rel=%0d: got %h expected %h", rel, bus.src_addr, cfg_base + 16'(fetch_idx));
          end
          bus.src_ack  = 1'b1;
          bus.src_data = src_byte(bus.src_addr);
          fetch_idx++;
          req_wait = 0;
          if (cfg_rand) delay = int'($urandom_range(0, 2));
        end else begin
          bus.src_ack  = 1'b0;
          bus.src_data = 8'($urandom);
          req_wait++;
        end
      end else begin
        req_wait     = 0;
        bus.src_ack  = cfg_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
        bus.src_data = 8'($urandom);
      end
      // Control and CPU traffic.
      bus.start    = (rel == 0) || (rel == cfg_start2_at);
      bus.src_base = (rel == 0) ? cfg_base : 16'($urandom);
      bus.abort    = (rel == cfg_abort_at);
      if (cfg_rand) begin
        bus.writable         = ($urandom_range(0, 3) != 0);
        bus.cpu_write_enable = ($urandom_range(0, 4) == 0);
        bus.cpu_address      = 12'($urandom);
        bus.cpu_data         = 8'($urandom);
      end else begin
        bus.writable         = !(rel >= cfg_wl_from && rel < cfg_wl_from + cfg_wl_len);
        bus.cpu_write_enable = (rel == cfg_cpu_at);
        bus.cpu_address      = 12'h123;
        bus.cpu_data         = 8'hAA;
      end

      if (rel == cfg_rst_at) begin
        // Reset between edges: outputs must drop without any clock.
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.src_req !== 1'b0 || bus.src_addr !== 16'h0) begin
          n_fail++;
          $display("FAIL rst_async_ctrl: busy=%b done=%b req=%b addr=%h expected 0 0 0 0000",
                   bus.busy, bus.done, bus.src_req, bus.src_addr);
        end
        n_checks++;
        if (bus.vram_write_enable !== 1'b0 || bus.vram_address !== DST || bus.vram_data !== 8'h00) begin
          n_fail++;
          $display("FAIL rst_async_vram: we=%b addr=%h data=%h expected 0 %h 00",
                   bus.vram_write_enable, bus.vram_address, bus.vram_data, DST);
        end
        bus.cpu_write_enable = 1'b1;
        #1;
        n_checks++;
        if (bus.vram_write_enable !== 1'b1 || bus.vram_address !== 12'h123) begin
          n_fail++;
          $display("FAIL rst_cpu_pass: we=%b addr=%h expected 1 123", bus.vram_write_enable, bus.vram_address);
        end
        bus.cpu_write_enable = 1'b0;
        finished = 1'b1;
      end else begin
        #3;
        if (bus.cpu_write_enable) begin
          n_checks++;
          if (bus.vram_write_enable !== 1'b1 || bus.vram_address !== bus.cpu_address ||
              bus.vram_data !== bus.cpu_data) begin
            n_fail++;
            $display("FAIL cpu_pass rel=%0d: got we=%b %h/%h expected 1 %h/%h", rel, bus.vram_write_enable,
                     bus.vram_address, bus.vram_data, bus.cpu_address, bus.cpu_data);
          end
        end else if (bus.vram_write_enable) begin
          n_checks++;
          if (!bus.writable || widx >= L || bus.vram_address !== DST + 12'(widx) ||
              bus.vram_data !== src_byte(cfg_base + 16'(widx))) begin
            n_fail++;
            $display("FAIL dma_write rel=%0d: got %h/%h writable=%b expected %h/%h writable=1", rel,
                     bus.vram_address, bus.vram_data, bus.writable, DST + 12'(widx),
                     src_byte(cfg_base + 16'(widx)));
          end
          if (widx < L) wcyc[widx] = rel;
          widx++;
        end
        exp_busy = (rel >= 1) && (done_rel < 0) && (cfg_abort_at < 0 || rel <= cfg_abort_at);
        n_checks++;
        if (bus.busy !== exp_busy) begin
          n_fail++;
          $display("FAIL busy rel=%0d: got %b expected %b", rel, bus.busy, exp_busy);
        end
        if (bus.done === 1'b1) begin
          done_cnt++;
          if (done_rel < 0) done_rel = rel;
        end
        if ((done_rel >= 0 && rel == done_rel + 1) || (cfg_abort_at >= 0 && rel == cfg_abort_at + 1))
          finished = 1'b1;
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (!finished) begin
      n_fail++;
      $display("FAIL timeout: transfer did not complete within 4000 cycles (writes=%0d)", widx);
    end
    if (cfg_rst_at < 0) idle_inputs();
  endtask

  task automatic expect_int(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    #2;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.src_req !== 1'b0 || bus.src_addr !== 16'h0 ||
        bus.vram_write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b req=%b addr=%h we=%b expected all zero",
               bus.busy, bus.done, bus.src_req, bus.src_addr, bus.vram_write_enable);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_default();
    set_defaults(16'h1200);
    run_xfer();
    expect_int("default_done_cycle", done_rel, 2 * L + 2);
    expect_int("default_done_count", done_cnt, 1);
    expect_int("default_writes", widx, L);
    expect_int("default_first_write", wcyc[0], 3);
    expect_int("default_last_write", wcyc[L-1], 2 * L + 1);
  endtask

  task automatic test_cpu_collision();
    set_defaults(16'h1200);
    cfg_cpu_at = 3 + 2 * 5;
    run_xfer();
    expect_int("collide_byte4", wcyc[4], 11);
    expect_int("collide_byte5", wcyc[5], 14);
    expect_int("collide_done_cycle", done_rel, 2 * L + 3);
    expect_int("collide_writes", widx, L);
  endtask

  task automatic test_writable_gap();
    set_defaults(16'h1200);
    cfg_wl_from = 3 + 2 * 100;
    cfg_wl_len  = 40;
    run_xfer();
    expect_int("gap_byte99", wcyc[99], 201);
    expect_int("gap_byte100", wcyc[100], 243);
    expect_int("gap_done_cycle", done_rel, 2 * L + 2 + 40);
    expect_int("gap_writes", widx, L);
  endtask

  task automatic test_slow_ack();
    set_defaults(16'h0040);
    cfg_ack_delay = 3;
    run_xfer();
    expect_int("slow_done_cycle", done_rel, 2 + 5 * L);
    expect_int("slow_writes", widx, L);
  endtask

  task automatic test_back_to_back();
    set_defaults(16'h2000);
    cfg_start2_at = 3 + 2 * 20;
    run_xfer();
    expect_int("restart_done_cycle", done_rel, 2 * L + 2);
    expect_int("restart_writes", widx, L);
    expect_int("restart_done_count", done_cnt, 1);
    set_defaults(16'h2100);
    cfg_abort_at = 3 + 2 * 10;
    run_xfer();
    expect_int("abort_writes", widx, 10);
    expect_int("abort_done_count", done_cnt, 0);
  endtask

  task automatic test_reset_mid_fetch();
    set_defaults(16'h1200);
    cfg_rst_at = 2 + 2 * 7;
    run_xfer();
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    set_defaults(16'h3400);
    cfg_xor = 8'h3C;
    run_xfer();
    expect_int("post_reset_done_cycle", done_rel, 2 * L + 2);
    expect_int("post_reset_writes", widx, L);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      set_defaults((r == 0) ? (16'hFFA0 + 16'($urandom_range(0, 15))) : 16'($urandom));
      cfg_xor  = 8'($urandom);
      cfg_rand = 1'b1;
      run_xfer();
      expect_int("random_writes", widx, L);
      expect_int("random_done_count", done_cnt, 1);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_cpu_collision();
    test_writable_gap();
    test_slow_ack();
    test_back_to_back();
    test_reset_mid_fetch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
